// File: rtl/aq_djpeg_bitfetch_pkg.sv
// Shared constants for the JPEG entropy-stream bit fetcher: FSM encodings,
// marker byte codes and the restart-marker classifier.
package aq_djpeg_bitfetch_pkg;

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_IMG  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_END  = 2'd3;

  localparam logic [7:0] MARK_FF  = 8'hFF;
  localparam logic [7:0] MARK_00  = 8'h00;
  localparam logic [7:0] MARK_RST = 8'hD0;
  localparam logic [7:0] MASK_RST = 8'hF8;

  function automatic logic is_rst_marker(input logic [7:0] code);
    return (code & MASK_RST) == MARK_RST;
  endfunction

endpackage

// File: rtl/aq_djpeg_bitfetch_unstuff.sv
// Combinational byte classifier: strips FF00 stuffing and FF fill bytes from
// one input word in scan mode and reports the first marker it meets.
module aq_djpeg_unstuff
  import aq_djpeg_bitfetch_pkg::*;
#(
  parameter int IN_BYTES = 4,
  parameter int CW       = $clog2(IN_BYTES) + 1
) (
  input  logic [8*IN_BYTES-1:0] data_i,
  input  logic [CW-1:0]         nbytes_i,
  input  logic                  img_i,
  input  logic                  pend_i,
  output logic [8*IN_BYTES-1:0] packed_o,
  output logic [CW-1:0]         count_o,
  output logic                  marker_o,
  output logic [CW-1:0]         pos_o,
  output logic [7:0]            code_o,
  output logic                  pend_o
);

  logic [7:0] b;
  logic       pend;
  logic       found;
  int         cnt;

  // Walk the bytes in stream order; packed_o fills from byte 0 upward.
  always_comb begin
    packed_o = '0;
    cnt      = 0;
    pend     = pend_i;
    found    = 1'b0;
    pos_o    = '0;
    code_o   = 8'h00;
    b        = 8'h00;
    for (int i = 0; i < IN_BYTES; i++) begin
      b = data_i[8*i +: 8];
      if (!found && (i < int'(nbytes_i))) begin
        if (!img_i) begin
          packed_o[8*cnt +: 8] = b;
          cnt = cnt + 1;
        end else if (pend) begin
          if (b == MARK_00) begin
            packed_o[8*cnt +: 8] = MARK_FF;
            cnt  = cnt + 1;
            pend = 1'b0;
          end else if (b == MARK_FF) begin
            pend = 1'b1;
          end else begin
            found  = 1'b1;
            pos_o  = CW'(i);
            code_o = b;
            pend   = 1'b0;
          end
        end else if (b == MARK_FF) begin
          pend = 1'b1;
        end else begin
          packed_o[8*cnt +: 8] = b;
          cnt = cnt + 1;
        end
      end
    end
    count_o  = CW'(cnt);
    marker_o = found;
    pend_o   = pend;
  end

endmodule

// File: rtl/aq_djpeg_bitfetch.sv
// JPEG bit fetcher: MSB-aligned bit buffer fed from the input FIFO, with
// marker hold/end handling and a registered OUT_WIDTH-bit look-ahead window.
module aq_djpeg_bitfetch
  import aq_djpeg_bitfetch_pkg::*;
#(
  parameter int IN_BYTES  = 4,
  parameter int OUT_WIDTH = 32,
  parameter int BUF_BITS  = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [8*IN_BYTES-1:0]          DataIn,
  input  logic                           DataInEnable,
  output logic                           DataInRead,
  input  logic                           ImageEnable,
  input  logic                           ProcessIdle,
  output logic [OUT_WIDTH-1:0]           DataOut,
  output logic                           DataOutEnable,
  input  logic                           UseBit,
  input  logic [$clog2(OUT_WIDTH):0]     UseWidth,
  input  logic                           UseByte,
  input  logic                           UseWord,
  input  logic                           ByteAlign,
  output logic                           MarkerValid,
  output logic [7:0]                     MarkerCode,
  input  logic                           MarkerAck,
  output logic                           DataEnd,
  output logic                           UnderflowErr,
  output logic [$clog2(BUF_BITS):0]      FillLevel
);

  localparam int IW = 8 * IN_BYTES;
  localparam int FW = $clog2(BUF_BITS) + 1;
  localparam int CW = $clog2(IN_BYTES) + 1;

  logic [1:0]           state_q, state_d;
  logic [BUF_BITS-1:0]  buf_q, buf_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic                 pend_q, pend_d;
  logic [IW-1:0]        skid_data_q, skid_data_d;
  logic [CW-1:0]        skid_cnt_q, skid_cnt_d;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                 doe_q, doe_d;
  logic                 mv_q, mv_d;
  logic [7:0]           mc_q, mc_d;
  logic                 dend_q, dend_d;
  logic                 uerr_q, uerr_d;

  logic [FW-1:0]        cons, fill_a, fill_c, app_bits;
  logic [BUF_BITS-1:0]  buf_a, buf_c;
  logic                 cons_any, uflow, room;
  logic                 skid_sel, din_read, u_go;
  logic [IW-1:0]        u_data, u_packed, app_raw, app_vec;
  logic [CW-1:0]        u_cnt, u_count, u_pos;
  logic                 u_marker, u_pend;
  logic [7:0]           u_code;

  // Byte alignment trims the tail of the buffer before any consume is applied.
  always_comb begin
    cons_any = UseBit | UseByte | UseWord;
    if (UseBit) begin
      cons = FW'(UseWidth);
    end else if (UseByte) begin
      cons = FW'(8);
    end else if (UseWord) begin
      cons = FW'(16);
    end else begin
      cons = '0;
    end
    if (ByteAlign) begin
      fill_a = {fill_q[FW-1:3], 3'b000};
      buf_a  = buf_q & ~({BUF_BITS{1'b1}} >> fill_a);
    end else begin
      fill_a = fill_q;
      buf_a  = buf_q;
    end
    if (cons > fill_a) begin
      fill_c = '0;
      buf_c  = '0;
      uflow  = 1'b1;
    end else begin
      fill_c = fill_a - cons;
      buf_c  = buf_a << cons;
      uflow  = 1'b0;
    end
    room = ({1'b0, fill_c} + (FW+1)'(IW)) <= (FW+1)'(BUF_BITS);
  end

  // Bytes parked behind an RSTn marker are drained before the FIFO is read again.
  always_comb begin
    skid_sel = (state_q == ST_IMG) && ImageEnable && (skid_cnt_q != '0);
    din_read = DataInEnable && room &&
               ((state_q == ST_HDR) ||
                ((state_q == ST_IMG) && ImageEnable && (skid_cnt_q == '0)));
    u_go     = din_read || (skid_sel && room);
    u_data   = skid_sel ? skid_data_q : DataIn;
    u_cnt    = skid_sel ? skid_cnt_q : CW'(IN_BYTES);
  end

  assign DataInRead = din_read;

  aq_djpeg_unstuff #(
    .IN_BYTES (IN_BYTES),
    .CW       (CW)
  ) u_unstuff (
    .data_i   (u_data),
    .nbytes_i (u_cnt),
    .img_i    (ImageEnable),
    .pend_i   (pend_q),
    .packed_o (u_packed),
    .count_o  (u_count),
    .marker_o (u_marker),
    .pos_o    (u_pos),
    .code_o   (u_code),
    .pend_o   (u_pend)
  );

  // FSM, append of classified bytes, marker capture and output window update.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    skid_data_d = skid_data_q;
    skid_cnt_d  = skid_cnt_q;
    mv_d        = mv_q;
    mc_d        = mc_q;
    dend_d      = dend_q;
    uerr_d      = uerr_q | uflow;
    app_vec     = '0;
    app_bits    = '0;
    app_raw     = '0;
    for (int k = 0; k < IN_BYTES; k++) begin
      app_raw[IW-1-8*k -: 8] = u_packed[8*k +: 8];
    end

    case (state_q)
      ST_HDR: begin
        if (ImageEnable) begin
          state_d = ST_IMG;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_IMG: begin
        // Leaving scan mode with an FF still pending: it was data, not a marker prefix.
        if (!ImageEnable && (!pend_q || room)) begin
          state_d = ST_HDR;
          pend_d  = 1'b0;
          if (pend_q) begin
            app_vec  = {MARK_FF, {(IW-8){1'b0}}};
            app_bits = FW'(8);
          end else begin
            app_bits = '0;
          end
        end else begin
          state_d = ST_IMG;
        end
      end
      ST_HOLD: begin
        if (MarkerAck) begin
          state_d = ST_IMG;
          mv_d    = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_END: begin
        state_d = ST_END;
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase

    if (u_go) begin
      app_vec  = app_raw;
      app_bits = FW'({u_count, 3'b000});
      pend_d   = u_pend;
      if (skid_sel) begin
        skid_cnt_d = '0;
      end else begin
        skid_cnt_d = skid_cnt_q;
      end
      if (u_marker) begin
        mv_d = 1'b1;
        mc_d = u_code;
        if (is_rst_marker(u_code)) begin
          state_d     = ST_HOLD;
          skid_data_d = u_data >> (8 * (int'(u_pos) + 1));
          skid_cnt_d  = u_cnt - u_pos - CW'(1);
        end else begin
          state_d    = ST_END;
          dend_d     = 1'b1;
          skid_cnt_d = '0;
        end
      end else begin
        mv_d = mv_q;
      end
    end else begin
      pend_d = pend_d;
    end

    buf_d  = buf_c | ({app_vec, {(BUF_BITS-IW){1'b0}}} >> fill_c);
    fill_d = fill_c + app_bits;

    if ((state_q == ST_END) && ProcessIdle) begin
      state_d    = ST_HDR;
      buf_d      = '0;
      fill_d     = '0;
      pend_d     = 1'b0;
      skid_cnt_d = '0;
      mv_d       = 1'b0;
      mc_d       = 8'h00;
      dend_d     = 1'b0;
    end else begin
      state_d = state_d;
    end

    dout_d = buf_d[BUF_BITS-1 -: OUT_WIDTH];
    doe_d  = !cons_any &&
             ((fill_d >= FW'(OUT_WIDTH)) ||
              ((fill_d != '0) && ((state_d == ST_HOLD) || (state_d == ST_END))));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HDR;
      buf_q       <= '0;
      fill_q      <= '0;
      pend_q      <= 1'b0;
      skid_data_q <= '0;
      skid_cnt_q  <= '0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      mv_q        <= 1'b0;
      mc_q        <= 8'h00;
      dend_q      <= 1'b0;
      uerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      pend_q      <= pend_d;
      skid_data_q <= skid_data_d;
      skid_cnt_q  <= skid_cnt_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      mv_q        <= mv_d;
      mc_q        <= mc_d;
      dend_q      <= dend_d;
      uerr_q      <= uerr_d;
    end
  end

  assign DataOut       = dout_q;
  assign DataOutEnable = doe_q;
  assign MarkerValid   = mv_q;
  assign MarkerCode    = mc_q;
  assign DataEnd       = dend_q;
  assign UnderflowErr  = uerr_q;
  assign FillLevel     = fill_q;

endmodule

// File: tb/tb_aq_djpeg_bitfetch.sv
// Directed bench for aq_djpeg_bitfetch: header pass-through, unstuffing,
// RSTn hold/resume, EOI end handling and underflow.
module tb_aq_djpeg_bitfetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] DataIn;
  logic        DataInEnable, DataInRead, ImageEnable, ProcessIdle;
  logic [31:0] DataOut;
  logic        DataOutEnable, UseBit, UseByte, UseWord, ByteAlign;
  logic [5:0]  UseWidth;
  logic        MarkerValid, MarkerAck, DataEnd, UnderflowErr;
  logic [7:0]  MarkerCode;
  logic [7:0]  FillLevel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  aq_djpeg_bitfetch #(.IN_BYTES(4), .OUT_WIDTH(32), .BUF_BITS(128)) dut (
    .clk(clk), .rst(rst), .DataIn(DataIn), .DataInEnable(DataInEnable),
    .DataInRead(DataInRead), .ImageEnable(ImageEnable), .ProcessIdle(ProcessIdle),
    .DataOut(DataOut), .DataOutEnable(DataOutEnable), .UseBit(UseBit),
    .UseWidth(UseWidth), .UseByte(UseByte), .UseWord(UseWord), .ByteAlign(ByteAlign),
    .MarkerValid(MarkerValid), .MarkerCode(MarkerCode), .MarkerAck(MarkerAck),
    .DataEnd(DataEnd), .UnderflowErr(UnderflowErr), .FillLevel(FillLevel)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; DataIn = 32'h0; DataInEnable = 1'b0; ImageEnable = 1'b0;
    ProcessIdle = 1'b0; UseBit = 1'b0; UseWidth = 6'd0; UseByte = 1'b0;
    UseWord = 1'b0; ByteAlign = 1'b0; MarkerAck = 1'b0;
    #12;
    chk("rst_dout", DataOut, 64'h0);
    chk("rst_doe", DataOutEnable, 64'h0);
    chk("rst_fill", FillLevel, 64'h0);
    chk("rst_mv", MarkerValid, 64'h0);
    chk("rst_end", DataEnd, 64'h0);
    chk("rst_uerr", UnderflowErr, 64'h0);
    rst = 1'b1;
    step();

    // Header mode: bytes pass raw, byte 0 first.
    DataIn = 32'h11223344; DataInEnable = 1'b1;
    #1 chk("hdr_read", DataInRead, 64'h1);
    step();
    DataIn = 32'h55667788;
    step();
    DataInEnable = 1'b0;
    chk("hdr_fill", FillLevel, 64'd64);
    chk("hdr_dout", DataOut, 64'h44332211);
    chk("hdr_doe", DataOutEnable, 64'h1);
    UseWord = 1'b1;
    step();
    chk("hdr_fill48", FillLevel, 64'd48);
    chk("hdr_doe_cons", DataOutEnable, 64'h0);
    step();
    UseWord = 1'b0;
    chk("hdr_fill32", FillLevel, 64'd32);
    chk("hdr_dout2", DataOut, 64'h88776655);
    step();
    chk("hdr_doe2", DataOutEnable, 64'h1);
    UseBit = 1'b1; UseWidth = 6'd32;
    step();
    UseBit = 1'b0;
    chk("hdr_flush", FillLevel, 64'd0);

    // Scan mode: 12 FF 00 34 unstuffs to 12 FF 34.
    ImageEnable = 1'b1;
    DataIn = 32'h3400FF12; DataInEnable = 1'b1;
    step();
    DataInEnable = 1'b0;
    chk("stuff_fill", FillLevel, 64'd24);
    chk("stuff_dout", DataOut, 64'h12FF3400);
    chk("stuff_mv", MarkerValid, 64'h0);
    UseBit = 1'b1; UseWidth = 6'd24;
    step();
    UseBit = 1'b0;

    // FF at the end of one word, 00 at the start of the next.
    DataIn = 32'hFFCCBBAA; DataInEnable = 1'b1;
    step();
    chk("xw_fill1", FillLevel, 64'd24);
    DataIn = 32'h33221100;
    step();
    DataInEnable = 1'b0;
    chk("xw_fill2", FillLevel, 64'd56);
    chk("xw_dout", DataOut, 64'hAABBCCFF);
    UseBit = 1'b1; UseWidth = 6'd32;
    step();
    UseWidth = 6'd24;
    step();
    UseBit = 1'b0;
    chk("xw_flush", FillLevel, 64'd0);

    // Restart marker: AB FF D3 CD.
    DataIn = 32'hCDD3FFAB; DataInEnable = 1'b1;
    step();
    DataInEnable = 1'b0;
    chk("rst_m_fill", FillLevel, 64'd8);
    chk("rst_m_mv", MarkerValid, 64'h1);
    chk("rst_m_code", MarkerCode, 64'hD3);
    chk("rst_m_end", DataEnd, 64'h0);
    chk("rst_m_doe", DataOutEnable, 64'h1);
    chk("rst_m_dout", DataOut, 64'hAB000000);
    DataIn = 32'h01020304; DataInEnable = 1'b1;
    #1 chk("hold_noread", DataInRead, 64'h0);
    DataInEnable = 1'b0;
    ByteAlign = 1'b1; MarkerAck = 1'b1;
    step();
    ByteAlign = 1'b0; MarkerAck = 1'b0;
    chk("ack_mv", MarkerValid, 64'h0);
    chk("ack_fill", FillLevel, 64'd8);
    DataInEnable = 1'b1;
    #1 chk("skid_noread", DataInRead, 64'h0);
    step();
    DataInEnable = 1'b0;
    chk("skid_fill", FillLevel, 64'd16);
    chk("skid_dout", DataOut, 64'hABCD0000);
    UseByte = 1'b1;
    step();
    UseByte = 1'b0;
    chk("skid_cd", DataOut, 64'hCD000000);
    chk("skid_fill8", FillLevel, 64'd8);
    UseByte = 1'b1;
    step();
    UseByte = 1'b0;

    // End of image: 5A FF FF D9.
    DataIn = 32'hD9FFFF5A; DataInEnable = 1'b1;
    step();
    DataInEnable = 1'b0;
    chk("eoi_fill", FillLevel, 64'd8);
    chk("eoi_end", DataEnd, 64'h1);
    chk("eoi_mv", MarkerValid, 64'h1);
    chk("eoi_code", MarkerCode, 64'hD9);
    chk("eoi_doe", DataOutEnable, 64'h1);
    chk("eoi_dout", DataOut, 64'h5A000000);
    ProcessIdle = 1'b1;
    step();
    ProcessIdle = 1'b0;
    chk("idle_mv", MarkerValid, 64'h0);
    chk("idle_end", DataEnd, 64'h0);
    chk("idle_fill", FillLevel, 64'd0);
    chk("idle_doe", DataOutEnable, 64'h0);

    // Consume and refill in the same cycle, then underflow.
    DataIn = 32'h04030201; DataInEnable = 1'b1;
    step();
    DataIn = 32'h08070605; UseBit = 1'b1; UseWidth = 6'd24;
    step();
    chk("cr_fill40", FillLevel, 64'd40);
    chk("cr_dout", DataOut, 64'h04050607);
    DataIn = 32'h0C0B0A09; UseWidth = 6'd32;
    step();
    DataInEnable = 1'b0; UseBit = 1'b0;
    chk("cr_fill_same", FillLevel, 64'd40);
    chk("cr_dout2", DataOut, 64'h08090A0B);
    chk("cr_uerr0", UnderflowErr, 64'h0);
    UseBit = 1'b1; UseWidth = 6'd48;
    step();
    UseBit = 1'b0;
    chk("uf_fill", FillLevel, 64'd0);
    chk("uf_err", UnderflowErr, 64'h1);
    chk("uf_doe", DataOutEnable, 64'h0);
    step();
    chk("uf_sticky", UnderflowErr, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
